tage_t0_base: RTL and testbench

//  TAGE base predictor T0: a direct-mapped table of 2-bit saturating counters.

---
 rtl/tage_pkg.sv | 20 ++
 rtl/tage_t0_base.sv | 50 +++++
 tb/tb_tage_t0_base.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tage_pkg.sv
// Shared TAGE definitions: 2-bit counter type, named counter states and the
// saturating counter update used by the base predictor.
package tage_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT = 2'b00;
  localparam ctr2_t CTR_WNT = 2'b01;
  localparam ctr2_t CTR_WT  = 2'b10;
  localparam ctr2_t CTR_ST  = 2'b11;

  // Saturates at both ends; never wraps between strong states.
  function automatic ctr2_t ctr_sat_update(ctr2_t c, logic taken);
    ctr2_t n;
    if (taken) n = (c == CTR_ST)  ? CTR_ST  : c + 2'd1;
    else       n = (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/tage_t0_base.sv
// TAGE base component T0: direct-mapped table of 2-bit counters indexed by
// PC xor the two youngest global-history bits, with one training port.
module tage_t0_base
  import tage_pkg::*;
#(
  parameter int    IDX_BITS = 10,
  parameter ctr2_t CTR_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ghr_t0,
  input  logic [31:0] branch_pc,
  output logic [1:0]  branch_pred,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [1:0]  update_pred
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // No handshake: predict is a pure combinational lookup, and an update with
  // update_valid=1 is always accepted at the next rising edge.

  ctr2_t               ctr_table [ENTRIES];
  logic [IDX_BITS-1:0] ghr_ext;
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] upd_idx;

  assign ghr_ext  = {{(IDX_BITS-2){1'b0}}, ghr_t0};
  assign pred_idx = branch_pc[IDX_BITS+1:2] ^ ghr_ext;
  assign upd_idx  = update_pc[IDX_BITS+1:2] ^ ghr_ext;

  assign branch_pred = ctr_table[pred_idx];

  // The new counter derives from the caller's predict-time value, not from
  // the table, so in-flight updates to one entry do not compound.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= CTR_INIT;
    end else if (update_valid) begin
      ctr_table[upd_idx] <= ctr_sat_update(update_pred, update_taken);
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{branch_pc[31:IDX_BITS+2], branch_pc[1:0],
                            update_pc[31:IDX_BITS+2], update_pc[1:0]};

endmodule

// File: tb/tb_tage_t0_base.sv
// Directed bench for tage_t0_base: reset, saturating training, indexing,
// history hashing, hold behaviour and reset during training.
module tb_tage_t0_base;

  logic        clk;
  logic        rst;
  logic [1:0]  ghr_t0;
  logic [31:0] branch_pc;
  logic [1:0]  branch_pred;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [1:0]  update_pred;

  int check_cnt;
  int pass_cnt;

  tage_t0_base #(.IDX_BITS(10), .CTR_INIT(2'b01)) dut (
    .clk          (clk),
    .rst          (rst),
    .ghr_t0       (ghr_t0),
    .branch_pc    (branch_pc),
    .branch_pred  (branch_pred),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .update_pred  (update_pred)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Driver tasks
  task automatic apply_update(input logic [31:0] pc, input logic [1:0] ghr,
                              input logic taken, input logic [1:0] pred);
    update_valid = 1'b1;
    update_pc    = pc;
    ghr_t0       = ghr;
    update_taken = taken;
    update_pred  = pred;
    @(posedge clk);
    #1 update_valid = 1'b0;
  endtask

  task automatic probe(input logic [31:0] pc, input logic [1:0] ghr);
    branch_pc = pc;
    ghr_t0    = ghr;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    probe(32'h0, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b01) $display("FAIL reset_pc0: got %b expected 01", branch_pred);
    else pass_cnt++;
    probe(32'h0000_0ffc, 2'b11);
    check_cnt++;
    if (branch_pred !== 2'b01) $display("FAIL reset_pc_ffc: got %b expected 01", branch_pred);
    else pass_cnt++;
  endtask

  task automatic test_train_taken();
    logic [1:0] exp_seq [3];
    exp_seq = '{2'b10, 2'b11, 2'b11};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      probe(32'h0, 2'b00);
      apply_update(32'h0, 2'b00, 1'b1, branch_pred);
      #1;
      check_cnt++;
      if (branch_pred !== exp_seq[i])
        $display("FAIL taken_step%0d: got %b expected %b", i, branch_pred, exp_seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_train_not_taken();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'b10, 2'b01, 2'b00, 2'b00};
    // Entry at PC 0 is 11 from the previous test.
    for (int i = 0; i < 4; i++) begin
      probe(32'h0, 2'b00);
      apply_update(32'h0, 2'b00, 1'b0, branch_pred);
      #1;
      check_cnt++;
      if (branch_pred !== exp_seq[i])
        $display("FAIL not_taken_step%0d: got %b expected %b", i, branch_pred, exp_seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_read_during_write();
    do_reset();
    probe(32'h0000_0010, 2'b00);
    update_valid = 1'b1;
    update_pc    = 32'h0000_0010;
    update_taken = 1'b1;
    update_pred  = 2'b01;
    #1;
    check_cnt++;
    if (branch_pred !== 2'b01) $display("FAIL rdw_old: got %b expected 01", branch_pred);
    else pass_cnt++;
    @(posedge clk);
    #1 update_valid = 1'b0;
    #1;
    check_cnt++;
    if (branch_pred !== 2'b10) $display("FAIL rdw_new: got %b expected 10", branch_pred);
    else pass_cnt++;
  endtask

  task automatic test_index_isolation();
    do_reset();
    apply_update(32'h0, 2'b00, 1'b1, 2'b01);
    apply_update(32'h0, 2'b00, 1'b1, 2'b10);
    probe(32'h0000_0004, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b01) $display("FAIL iso_pc4: got %b expected 01", branch_pred);
    else pass_cnt++;
    probe(32'h0000_1000, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b11) $display("FAIL iso_alias_1000: got %b expected 11", branch_pred);
    else pass_cnt++;
    probe(32'h0000_0003, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b11) $display("FAIL iso_low_bits: got %b expected 11", branch_pred);
    else pass_cnt++;
  endtask

  task automatic test_history_hash();
    do_reset();
    apply_update(32'h0000_0008, 2'b00, 1'b1, 2'b10);
    probe(32'h0000_0008, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b11) $display("FAIL hash_pc8_g0: got %b expected 11", branch_pred);
    else pass_cnt++;
    probe(32'h0000_0008, 2'b01);
    check_cnt++;
    if (branch_pred !== 2'b01) $display("FAIL hash_pc8_g1: got %b expected 01", branch_pred);
    else pass_cnt++;
    probe(32'h0000_000c, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b01) $display("FAIL hash_pcc_g0: got %b expected 01", branch_pred);
    else pass_cnt++;
    // idx 0 ^ 2 = 2, same entry as PC 0x8 with ghr 00
    probe(32'h0000_0000, 2'b10);
    check_cnt++;
    if (branch_pred !== 2'b11) $display("FAIL hash_pc0_g2: got %b expected 11", branch_pred);
    else pass_cnt++;
    // Update under ghr=01 lands at idx 2^1=3
    apply_update(32'h0000_0008, 2'b01, 1'b0, 2'b01);
    probe(32'h0000_000c, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b00) $display("FAIL hash_upd_idx3: got %b expected 00", branch_pred);
    else pass_cnt++;
  endtask

  task automatic test_update_uses_pred();
    do_reset();
    // Table holds 01; supplied pred 11 with not-taken must give 10.
    apply_update(32'h0000_0020, 2'b00, 1'b0, 2'b11);
    probe(32'h0000_0020, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b10) $display("FAIL uses_pred_dec: got %b expected 10", branch_pred);
    else pass_cnt++;
    apply_update(32'h0000_0024, 2'b00, 1'b1, 2'b00);
    probe(32'h0000_0024, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b01) $display("FAIL uses_pred_inc: got %b expected 01", branch_pred);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    update_valid = 1'b0;
    update_pc    = 32'h0000_0020;
    update_taken = 1'b1;
    update_pred  = 2'b11;
    ghr_t0       = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    probe(32'h0000_0020, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b10) $display("FAIL hold: got %b expected 10", branch_pred);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_training();
    apply_update(32'h0000_0040, 2'b00, 1'b1, 2'b10);
    probe(32'h0000_0040, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b11) $display("FAIL mid_pre: got %b expected 11", branch_pred);
    else pass_cnt++;
    rst          = 1'b0;
    update_valid = 1'b1;
    update_pc    = 32'h0000_0044;
    update_taken = 1'b1;
    update_pred  = 2'b10;
    @(posedge clk);
    #1;
    rst          = 1'b1;
    update_valid = 1'b0;
    probe(32'h0000_0040, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b01) $display("FAIL mid_entry: got %b expected 01", branch_pred);
    else pass_cnt++;
    probe(32'h0000_0044, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b01) $display("FAIL mid_discard: got %b expected 01", branch_pred);
    else pass_cnt++;
    probe(32'h0000_0020, 2'b00);
    check_cnt++;
    if (branch_pred !== 2'b01) $display("FAIL mid_other: got %b expected 01", branch_pred);
    else pass_cnt++;
  endtask

  initial begin
    check_cnt    = 0;
    pass_cnt     = 0;
    rst          = 1'b0;
    ghr_t0       = 2'b00;
    branch_pc    = 32'h0;
    update_valid = 1'b0;
    update_pc    = 32'h0;
    update_taken = 1'b0;
    update_pred  = 2'b00;
    #2;
    test_reset();
    test_train_taken();
    test_train_not_taken();
    test_read_during_write();
    test_index_isolation();
    test_history_hash();
    test_update_uses_pred();
    test_hold();
    test_reset_mid_training();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
